// File: rtl/fpga_rst_pkg.sv
// Shared types for the FPGA reset sequencer: FSM state codes, reset-cause codes
// and a counter-width helper.
package fpga_rst_pkg;

   typedef enum logic [1:0] {
      StHold     = 2'd0,
      StLockWait = 2'd1,
      StRelease  = 2'd2,
      StRun      = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CausePor  = 2'd0,
      CauseExt  = 2'd1,
      CauseLock = 2'd2,
      CauseSw   = 2'd3
   } cause_e;

   // Wide enough to hold max_val without wrapping.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val) + 1;
   endfunction

endpackage

// File: rtl/fpga_rst_debounce.sv
// Synchroniser followed by a symmetric debounce filter: the output follows the
// synchronised input only after it has disagreed for DEBOUNCE_CYC consecutive cycles.
module fpga_rst_debounce
   import fpga_rst_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DEBOUNCE_CYC = 50000
) (
   input  logic clk,
   input  logic rst_b,
   input  logic async_i,
   output logic deb_o
);

   localparam int unsigned CntW = cnt_width(DEBOUNCE_CYC);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   deb_q, deb_d;
   logic                   in_s;

   assign in_s  = sync_q[SYNC_STAGES-1];
   assign deb_o = deb_q;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
      deb_d  = deb_q;
      cnt_d  = '0;
      if (in_s != deb_q) begin
         if (cnt_q >= CntLast) begin
            deb_d = in_s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         sync_q <= '0;
         cnt_q  <= '0;
         deb_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
      end
   end

endmodule

// File: rtl/fpga_rst_seq.sv
// Staged domain reset sequencer: waits for a stable PLL lock and a clean reset pad,
// then releases each domain reset in order; any fault re-asserts all of them.
module fpga_rst_seq
   import fpga_rst_pkg::*;
#(
   parameter int unsigned NUM_DOM       = 3,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned DEBOUNCE_CYC  = 50000,
   parameter int unsigned LOCK_WAIT_CYC = 1024,
   parameter int unsigned STAGE_GAP_CYC = 16,
   parameter int unsigned MIN_HOLD_CYC  = 32
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic               pll_locked_i,
   input  logic               ext_rst_b_i,
   input  logic               sw_rst_req_i,
   output logic [NUM_DOM-1:0] dom_rst_b_o,
   output logic               all_released_o,
   output logic [1:0]         rst_cause_o,
   output logic [1:0]         state_o
);

   localparam int unsigned MaxHw  = (MIN_HOLD_CYC > LOCK_WAIT_CYC) ? MIN_HOLD_CYC : LOCK_WAIT_CYC;
   localparam int unsigned MaxCyc = (MaxHw > STAGE_GAP_CYC) ? MaxHw : STAGE_GAP_CYC;
   localparam int unsigned CntW   = cnt_width(MaxCyc);
   localparam int unsigned IdxW   = cnt_width(NUM_DOM);

   localparam logic [CntW-1:0] HoldLast = CntW'(MIN_HOLD_CYC - 1);
   localparam logic [CntW-1:0] WaitLast = CntW'(LOCK_WAIT_CYC - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP_CYC - 1);
   localparam logic [CntW-1:0] CntMax   = '1;
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_DOM - 1);

   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   lock_s;
   logic                   ext_deb;

   state_e              state_q;
   cause_e              cause_q;
   cause_e              abort_cause;
   logic                abort;
   logic [CntW-1:0]     cnt_q;
   logic [IdxW-1:0]     idx_q;
   logic [NUM_DOM-1:0]  dom_q;
   logic [NUM_DOM-1:0]  stage_mask;
   logic                all_q;

   fpga_rst_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_ext_debounce (
      .clk     (clk),
      .rst_b   (rst_b),
      .async_i (ext_rst_b_i),
      .deb_o   (ext_deb)
   );

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         lock_sync_q <= '0;
      end else begin
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      end
   end

   assign lock_s = lock_sync_q[SYNC_STAGES-1];

   // Lock loss outranks the pad, which outranks software; software only counts once releasing.
   always_comb begin
      abort       = 1'b0;
      abort_cause = CauseSw;
      if (!lock_s) begin
         abort       = 1'b1;
         abort_cause = CauseLock;
      end else if (!ext_deb) begin
         abort       = 1'b1;
         abort_cause = CauseExt;
      end else if (sw_rst_req_i && (state_q == StRelease || state_q == StRun)) begin
         abort       = 1'b1;
         abort_cause = CauseSw;
      end
   end

   always_comb begin
      stage_mask = '0;
      for (int i = 0; i < NUM_DOM; i++) begin
         if (idx_q == IdxW'(i)) begin
            stage_mask[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q <= StHold;
         cause_q <= CausePor;
         cnt_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '0;
         all_q   <= 1'b0;
      end else if (state_q != StHold && abort) begin
         state_q <= StHold;
         cnt_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '0;
         all_q   <= 1'b0;
         // An abort before any domain was released keeps the previous cause.
         if (state_q != StLockWait) begin
            cause_q <= abort_cause;
         end
      end else begin
         unique case (state_q)
            StHold: begin
               if (cnt_q >= HoldLast && lock_s && ext_deb) begin
                  state_q <= StLockWait;
                  cnt_q   <= '0;
               end else if (cnt_q != CntMax) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StLockWait: begin
               if (cnt_q >= WaitLast) begin
                  state_q <= (NUM_DOM == 1) ? StRun : StRelease;
                  cnt_q   <= '0;
                  idx_q   <= IdxW'(1);
                  dom_q   <= NUM_DOM'(1);
                  all_q   <= (NUM_DOM == 1);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StRelease: begin
               if (cnt_q >= GapLast) begin
                  cnt_q <= '0;
                  dom_q <= dom_q | stage_mask;
                  if (idx_q >= LastIdx) begin
                     state_q <= StRun;
                     all_q   <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StRun: begin
            end
         endcase
      end
   end

   assign dom_rst_b_o    = dom_q;
   assign all_released_o = all_q;
   assign rst_cause_o    = cause_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Scenario bench for fpga_rst_seq against a timestamp-based reference model.
module tb_fpga_rst_seq;

   localparam int NUM_DOM = 3;
   localparam int SYNC    = 2;
   localparam int DEB     = 8;
   localparam int LWAIT   = 16;
   localparam int GAP     = 4;
   localparam int HOLD    = 4;

   localparam int PHold = 0;
   localparam int PLw   = 1;
   localparam int PRel  = 2;
   localparam int PRun  = 3;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic lock = 1'b1;
   logic ext = 1'b1;
   logic sw = 1'b0;
   logic [NUM_DOM-1:0] dom;
   logic all_rel;
   logic [1:0] cause;
   logic [1:0] state;
   logic [7:0] obs_vec;
   logic [7:0] exp_vec = 8'h00;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: phase plus the edge index at which it was entered.
   int m_phase = PHold;
   int m_enter = 0;
   int m_rel = 0;
   int m_cause = 0;
   int m_diff = 0;
   bit m_deb = 1'b0;
   bit m_lk[SYNC];
   bit m_ex[SYNC];

   always #5 clk = ~clk;

   fpga_rst_seq #(
      .NUM_DOM       (NUM_DOM),
      .SYNC_STAGES   (SYNC),
      .DEBOUNCE_CYC  (DEB),
      .LOCK_WAIT_CYC (LWAIT),
      .STAGE_GAP_CYC (GAP),
      .MIN_HOLD_CYC  (HOLD)
   ) dut (
      .clk            (clk),
      .rst_b          (rst_b),
      .pll_locked_i   (lock),
      .ext_rst_b_i    (ext),
      .sw_rst_req_i   (sw),
      .dom_rst_b_o    (dom),
      .all_released_o (all_rel),
      .rst_cause_o    (cause),
      .state_o        (state)
   );

   assign obs_vec = {dom, all_rel, cause, state};

   // One clock edge: update the model from the inputs the DUT sees, then move to the negedge.
   task automatic step();
      bit l, e, s, r, lk_s, ex_s;
      logic [NUM_DOM-1:0] d;
      l = lock; e = ext; s = sw; r = rst_b;
      @(posedge clk);
      cyc++;
      lk_s = m_lk[SYNC-1];
      ex_s = m_ex[SYNC-1];
      if (!r) begin
         m_phase = PHold; m_enter = cyc; m_cause = 0; m_deb = 1'b0; m_diff = 0;
         for (int i = 0; i < SYNC; i++) begin m_lk[i] = 1'b0; m_ex[i] = 1'b0; end
      end else begin
         if (m_phase != PHold && (!lk_s || !m_deb || (s && m_phase >= PRel))) begin
            if (m_phase >= PRel) m_cause = !lk_s ? 2 : (!m_deb ? 1 : 3);
            m_phase = PHold; m_enter = cyc;
         end else if (m_phase == PHold && cyc - m_enter >= HOLD && lk_s && m_deb) begin
            m_phase = PLw; m_enter = cyc;
         end else if (m_phase == PLw && cyc - m_enter >= LWAIT) begin
            m_phase = (NUM_DOM == 1) ? PRun : PRel; m_enter = cyc; m_rel = cyc;
         end else if (m_phase == PRel && cyc - m_rel >= (NUM_DOM - 1) * GAP) begin
            m_phase = PRun;
         end
         if (ex_s != m_deb) begin
            m_diff++;
            if (m_diff == DEB) begin m_deb = ex_s; m_diff = 0; end
         end else begin
            m_diff = 0;
         end
         for (int i = SYNC - 1; i > 0; i--) begin m_lk[i] = m_lk[i-1]; m_ex[i] = m_ex[i-1]; end
         m_lk[0] = l; m_ex[0] = e;
      end
      for (int i = 0; i < NUM_DOM; i++) d[i] = (m_phase >= PRel) && (cyc - m_rel >= i * GAP);
      exp_vec = {d, m_phase == PRun, 2'(m_cause), 2'(m_phase)};
      @(negedge clk);
   endtask

   task automatic run_until(input int phase, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (m_phase == phase) break;
         step();
      end
      if (m_phase == phase) ok = 1'b1;
   endtask

   task automatic test_reset();
      rst_b = 1'b0; lock = 1'b1; ext = 1'b1; sw = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (obs_vec !== 8'h00) begin
            failures++; $display("FAIL reset k=%0d got %b want %b", k, obs_vec, 8'h00);
         end
      end
   endtask

   task automatic test_power_up();
      int t_first = -1;
      rst_b = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL power_up cyc=%0d got %b want %b", cyc, obs_vec, exp_vec);
         end
         if (t_first < 0 && dom[0] === 1'b1) t_first = k;
         if (t_first > 0 && k == t_first + 4) begin
            checks++;
            if (dom !== 3'b011) begin
               failures++; $display("FAIL stage1 got %b want %b", dom, 3'b011);
            end
         end
         if (t_first > 0 && k == t_first + 8) begin
            checks++;
            if ({dom, all_rel, cause} !== 6'b111100) begin
               failures++; $display("FAIL stage2 got %b want %b", {dom, all_rel, cause}, 6'b111100);
            end
         end
      end
      checks++;
      if (t_first != 27) begin
         failures++; $display("FAIL first_release got %0d want %0d", t_first, 27);
      end
   endtask

   task automatic test_lock_glitch();
      int len = int'($urandom_range(1, 7));
      lock = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         if (k == len + 1) lock = 1'b1;
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL lock_glitch cyc=%0d got %b want %b", cyc, obs_vec, exp_vec);
         end
         if (k == 3) begin
            checks++;
            if ({dom, all_rel, cause} !== 6'b000010) begin
               failures++; $display("FAIL lock_abort got %b want %b", {dom, all_rel, cause}, 6'b000010);
            end
         end
      end
      checks++;
      if (all_rel !== 1'b1 || cause !== 2'd2) begin
         failures++; $display("FAIL lock_rerelease got all=%b cause=%0d want 1/2", all_rel, cause);
      end
   endtask

   task automatic test_bounce();
      int p = int'($urandom_range(1, 7));
      for (int k = 0; k < 44; k++) begin
         ext = (k >= 40 || ((k / p) % 2) == 1) ? 1'b1 : 1'b0;
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL bounce cyc=%0d got %b want %b", cyc, obs_vec, exp_vec);
         end
      end
      checks++;
      if (dom !== 3'b111 || all_rel !== 1'b1) begin
         failures++; $display("FAIL bounce_no_reset got dom=%b all=%b want 111/1", dom, all_rel);
      end
      ext = 1'b0;
      for (int k = 0; k < 14; k++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL ext_hold cyc=%0d got %b want %b", cyc, obs_vec, exp_vec);
         end
      end
      checks++;
      if ({dom, all_rel, cause} !== 6'b000001) begin
         failures++; $display("FAIL ext_cause got %b want %b", {dom, all_rel, cause}, 6'b000001);
      end
      ext = 1'b1;
      for (int k = 0; k < 70; k++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL ext_recover cyc=%0d got %b want %b", cyc, obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_sw();
      int d = int'($urandom_range(0, 5));
      bit ok;
      repeat (d) step();
      sw = 1'b1; step(); sw = 1'b0;
      checks++;
      if (obs_vec !== 8'b000_0_11_00 || obs_vec !== exp_vec) begin
         failures++; $display("FAIL sw_abort got %b want %b", obs_vec, 8'b000_0_11_00);
      end
      run_until(PLw, 40, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL sw_reach_lockwait got 0 want 1"); end
      d = int'($urandom_range(0, 10));
      repeat (d) step();
      sw = 1'b1; step(); sw = 1'b0;
      checks++;
      if (state !== 2'd1 || cause !== 2'd3) begin
         failures++; $display("FAIL sw_in_lockwait got st=%0d cause=%0d want 1/3", state, cause);
      end
      for (int k = 0; k < 40; k++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL sw_recover cyc=%0d got %b want %b", cyc, obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      sw = 1'b1; step(); sw = 1'b0;
      run_until(PRel, 60, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL simul_reach_release got 0 want 1"); end
      lock = 1'b0;
      step(); step();
      sw = 1'b1; step(); sw = 1'b0; lock = 1'b1;
      checks++;
      if ({dom, all_rel, cause, state} !== 8'b000_0_10_00) begin
         failures++; $display("FAIL simul_cause got %b want %b", obs_vec, 8'b000_0_10_00);
      end
      for (int k = 0; k < 50; k++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL simul_recover cyc=%0d got %b want %b", cyc, obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_lockwait_abort();
      bit ok;
      ext = 1'b0;
      repeat (14) step();
      ext = 1'b1;
      run_until(PLw, 60, ok);
      checks++;
      if (!ok || cause !== 2'd1) begin
         failures++; $display("FAIL lw_setup got ok=%0d cause=%0d want 1/1", ok, cause);
      end
      lock = 1'b0;
      repeat (4) step();
      lock = 1'b1;
      checks++;
      if (state !== 2'd0 || cause !== 2'd1 || obs_vec !== exp_vec) begin
         failures++; $display("FAIL lw_lock_loss got st=%0d cause=%0d want 0/1", state, cause);
      end
      for (int k = 0; k < 70; k++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL lw_recover cyc=%0d got %b want %b", cyc, obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_rst_mid();
      bit ok;
      int d;
      sw = 1'b1; step(); sw = 1'b0;
      run_until(PRel, 60, ok);
      checks++;
      if (!ok || dom !== 3'b001) begin
         failures++; $display("FAIL rst_mid_setup got ok=%0d dom=%b want 1/001", ok, dom);
      end
      d = int'($urandom_range(0, 2));
      repeat (d) step();
      rst_b = 1'b0; step();
      checks++;
      if (obs_vec !== 8'h00) begin
         failures++; $display("FAIL rst_mid got %b want %b", obs_vec, 8'h00);
      end
      rst_b = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL rst_recover cyc=%0d got %b want %b", cyc, obs_vec, exp_vec);
         end
      end
      checks++;
      if (all_rel !== 1'b1 || cause !== 2'd0) begin
         failures++; $display("FAIL rst_rerelease got all=%b cause=%0d want 1/0", all_rel, cause);
      end
   endtask

   initial begin
      for (int i = 0; i < SYNC; i++) begin m_lk[i] = 1'b0; m_ex[i] = 1'b0; end
      @(negedge clk);
      test_reset();
      test_power_up();
      test_lock_glitch();
      test_bounce();
      test_sw();
      test_simultaneous();
      test_lockwait_abort();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
